// File: rtl/spike_rate_display.sv
// spike_rate_display: counts spike rising edges per window, latches a 4-bit rate and shows it as a hex glyph.
// Define SPIKE_RATE_OVF_FLASH_EN to blank the display in the second half of each window while overflow is set.
module spike_rate_display #(
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spike,
  input  logic       enable,
  output logic [3:0] rate,
  output logic       rate_valid,
  output logic       overflow,
  output logic [6:0] segments
);
  localparam int WW = $clog2(WINDOW_CYCLES);
  typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wc_q, wc_d;
  logic [3:0] cnt_q, cnt_d, rate_q, rate_d;
  logic acc_q, acc_d, ovf_q, ovf_d, spike_d_q, spk_edge;
  logic [6:0] glyph;
  assign spk_edge = spike & ~spike_d_q;
  always_comb begin
    state_d = state_q;
    wc_d = '0;
    cnt_d = '0;
    acc_d = 1'b0;
    rate_d = rate_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: state_d = enable ? COUNT : IDLE;
      COUNT: begin
        if (!enable) state_d = IDLE;
        else begin
          wc_d = wc_q + WW'(1);
          cnt_d = cnt_q + {3'b0, spk_edge && cnt_q != 4'hF};
          acc_d = acc_q | (spk_edge && cnt_q == 4'hF);
          if (wc_q == WW'(WINDOW_CYCLES - 1)) begin
            state_d = LATCH;
            rate_d = cnt_d;
            ovf_d = acc_d;
          end
        end
      end
      LATCH: begin
        // The latch cycle doubles as cycle 0 of the following window
        state_d = enable ? COUNT : IDLE;
        wc_d = enable ? WW'(1) : '0;
        cnt_d = enable ? {3'b0, spk_edge} : 4'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wc_q <= '0;
      cnt_q <= '0;
      acc_q <= 1'b0;
      rate_q <= '0;
      ovf_q <= 1'b0;
      spike_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q <= wc_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      rate_q <= rate_d;
      ovf_q <= ovf_d;
      spike_d_q <= spike;
    end
  end
  always_comb begin
    glyph = 7'h3F;
    case (rate_q)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h3F;
    endcase
  end
  assign rate = rate_q;
  assign overflow = ovf_q;
  assign rate_valid = state_q == LATCH;
`ifdef SPIKE_RATE_OVF_FLASH_EN
  assign segments = (ovf_q && state_q == COUNT && wc_q >= WW'(WINDOW_CYCLES / 2)) ? 7'h00 : glyph;
`else
  assign segments = glyph;
`endif
endmodule

// File: tb/tb_spike_rate_display.sv
// tb_spike_rate_display: scoreboard bench driving a 16-cycle and a 40-cycle window instance.
module tb_spike_rate_display;
  logic clk = 1'b0, rst = 1'b1, spike = 1'b0, enable = 1'b0, sel = 1'b0;
  logic sp16, en16, sp40, en40, rv16, rv40, ovf16, ovf40;
  logic [3:0] rate16, rate40;
  logic [6:0] seg16, seg40;
  int cyc = 0, checks = 0, failures = 0, pulses16 = 0, pulses40 = 0, c0, c1;
  typedef struct {
    int cyc;
    logic [3:0] r;
    logic o;
    logic [6:0] s;
  } exp_t;
  exp_t q16[$], q40[$];
  exp_t e16, e40;
  assign sp16 = sel ? 1'b0 : spike;
  assign en16 = sel ? 1'b0 : enable;
  assign sp40 = sel ? spike : 1'b0;
  assign en40 = sel ? enable : 1'b0;
  spike_rate_display #(.WINDOW_CYCLES(16)) dut16 (
    .clk(clk), .rst(rst), .spike(sp16), .enable(en16),
    .rate(rate16), .rate_valid(rv16), .overflow(ovf16), .segments(seg16)
  );
  spike_rate_display #(.WINDOW_CYCLES(40)) dut40 (
    .clk(clk), .rst(rst), .spike(sp40), .enable(en40),
    .rate(rate40), .rate_valid(rv40), .overflow(ovf40), .segments(seg40)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic s, input logic e);
    spike = s;
    enable = e;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [63:0] pat, input int from, input int to);
    for (int k = from; k < to; k++) step(pat[k], 1'b1);
  endtask
  task automatic push(input int c, input logic [3:0] r, input logic o, input logic [6:0] s);
    if (sel) q40.push_back('{c, r, o, s});
    else q16.push_back('{c, r, o, s});
  endtask
  always @(negedge clk) begin
    if (rv16) begin
      pulses16++;
      if (q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rv16_unexpected: got pulse at cyc %0d expected none", cyc);
      end else begin
        e16 = q16.pop_front();
        chk("rv16_cyc", cyc, e16.cyc);
        chk("rate16", rate16, e16.r);
        chk("ovf16", ovf16, e16.o);
        chk("seg16", seg16, e16.s);
      end
    end
    if (rv40) begin
      pulses40++;
      if (q40.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rv40_unexpected: got pulse at cyc %0d expected none", cyc);
      end else begin
        e40 = q40.pop_front();
        chk("rv40_cyc", cyc, e40.cyc);
        chk("rate40", rate40, e40.r);
        chk("ovf40", ovf40, e40.o);
        chk("seg40", seg40, e40.s);
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) step(i[0], 1'b1);
    chk("rst_rate", rate16, 0);
    chk("rst_ovf", ovf16, 0);
    chk("rst_rv", rv16, 0);
    chk("rst_seg", seg16, 7'h3F);
    chk("rst_seg40", seg40, 7'h3F);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step(i[0], 1'b0);
    chk("idle_no_pulse", pulses16, 0);
    // basic count: edges at window cycles 2, 7, 15 then an empty window
    step(0, 1);
    c0 = cyc;
    push(c0 + 16, 3, 0, 7'h4F);
    push(c0 + 32, 0, 0, 7'h3F);
    run(16'h8084, 0, 16);
    run(0, 0, 8);
    chk("hold_rate", rate16, 3);
    chk("hold_seg", seg16, 7'h4F);
    run(0, 8, 16);
    step(0, 0);
    // held level counts once; LATCH-cycle edge goes to the next window
    step(0, 1);
    c0 = cyc;
    push(c0 + 16, 1, 0, 7'h06);
    push(c0 + 32, 1, 0, 7'h06);
    run(16'h00F8, 0, 16);
    run(16'h0001, 0, 16);
    step(0, 0);
    // saturation on the 40-cycle instance
    sel = 1'b1;
    step(0, 1);
    c0 = cyc;
    push(c0 + 40, 15, 1, 7'h71);
    push(c0 + 80, 4, 0, 7'h66);
    run(64'h05_5555_5555, 0, 40);
    run(64'h55, 0, 5);
    chk("sat_seg_early", seg40, 7'h71);
    chk("sat_ovf_hold", ovf40, 1);
    run(64'h55, 5, 25);
`ifdef SPIKE_RATE_OVF_FLASH_EN
    chk("sat_seg_flash", seg40, 7'h00);
`else
    chk("sat_seg_late", seg40, 7'h71);
`endif
    run(64'h55, 25, 40);
    step(0, 0);
    sel = 1'b0;
    // abort mid-window keeps the old rate
    step(0, 1);
    c0 = cyc;
    push(c0 + 16, 2, 0, 7'h5B);
    run(16'h0022, 0, 16);
    run(16'h0155, 0, 10);
    step(0, 0);
    for (int i = 0; i < 20; i++) step(0, 0);
    chk("abort_rate", rate16, 2);
    chk("abort_seg", seg16, 7'h5B);
    step(0, 1);
    c1 = cyc;
    push(c1 + 16, 1, 0, 7'h06);
    run(16'h0008, 0, 16);
    step(0, 0);
    // reset mid-window discards the partial count
    step(0, 1);
    run(16'h0055, 0, 8);
    rst = 1'b1;
    step(0, 1);
    rst = 1'b0;
    chk("mid_rst_rate", rate16, 0);
    chk("mid_rst_seg", seg16, 7'h3F);
    chk("mid_rst_rv", rv16, 0);
    chk("mid_rst_rate40", rate40, 0);
    step(0, 1);
    c1 = cyc;
    push(c1 + 16, 1, 0, 7'h06);
    run(16'h0010, 0, 16);
    step(0, 0);
    for (int i = 0; i < 4; i++) step(0, 0);
    chk("q16_drained", q16.size(), 0);
    chk("q40_drained", q40.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spike_rate_display.md
Name: spike_rate_display

Overview:
- Sits directly downstream of the lif neuron and consumes its single-bit spike output.
- Counts spike rising edges over a fixed window of clock cycles and latches the count as a 4-bit rate.
- Decodes the rate to a hex digit on the board's 7-segment display.
- Gives the demo a human-readable firing-rate readout for a given input current.

Parameters:
- WINDOW_CYCLES, 1000, cycles per measurement window (legal range >= 2); window counter width is $clog2(WINDOW_CYCLES).

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- spike  input  1  spike level from the LIF neuron, synchronous to clk.
- enable  input  1  measurement enable.
- rate  output  4  last latched spike count, saturated at 15.
- rate_valid  output  1  one-cycle pulse when rate/overflow update.
- overflow  output  1  latched: more than 15 edges in the last window.
- segments  output  7  {g,f,e,d,c,b,a}, active-high, hex glyph of rate.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE; window counter, spike count, overflow accumulator and spike_d cleared.
  - Outputs: rate=0, rate_valid=0, overflow=0, segments=0x3F.
  - rst overrides every other input. Reset mid-window discards the partial count.
- Edge detect: edge = spike & ~spike_d, with spike_d the registered previous spike. A level held high for N cycles counts once.
- FSM states are IDLE, COUNT and LATCH.
- IDLE:
  - Counters held at 0; rate_valid=0.
  - enable sampled high -> COUNT with window counter 0.
  - Edges in IDLE are ignored; spike_d still tracks spike.
- COUNT:
  - Window counter increments each cycle.
  - On edge: count = count+1, saturating at 15. An edge arriving while count==15 sets the overflow accumulator.
  - Window counter == WINDOW_CYCLES-1 -> LATCH; that cycle's edge is included.
  - enable low -> IDLE. The partial window is discarded, rate_valid does not pulse, and rate/overflow hold their old values. The enable-low check takes priority over the transition to LATCH.
- LATCH (exactly one cycle):
  - Registered on entry: rate = final count, overflow = overflow accumulator, rate_valid = 1.
  - This cycle is cycle 0 of the next window:
    - count = 1 if edge else 0;
    - overflow accumulator cleared;
    - window counter = 1.
  - enable high -> COUNT; else -> IDLE.
  - With WINDOW_CYCLES==2 the next window's last cycle is the cycle after LATCH.
- Timing:
  - First rate_valid is high in cycle WINDOW_CYCLES+1 after the edge that sampled enable high.
  - Thereafter rate_valid pulses every WINDOW_CYCLES cycles while enable stays high.
  - rate_valid never stays high for two consecutive cycles.
- segments is combinationally decoded from the rate register and changes in the same cycle as rate. Glyphs:
  - 0..7 = 3F 06 5B 4F 66 6D 7D 07
  - 8..F = 7F 6F 77 7C 39 5E 79 71
- rate, overflow and segments hold between windows.

Optional Feature:
- Macro SPIKE_RATE_OVF_FLASH_EN.
- Defined: while overflow==1 and state is COUNT with window counter >= WINDOW_CYCLES/2, segments are forced to 0x00. The glyph 0x71 blinks once per window.
- Not defined: segments is always the decoded glyph of rate. No extra logic is synthesised.

Test Plan:
- Reset: hold rst 3 cycles with spike toggling -> rate=0, overflow=0, rate_valid=0, segments=0x3F. No rate_valid for 20 cycles while enable=0.
- Basic count, WINDOW_CYCLES=16: enable high; 3 one-cycle spikes at window cycles 2, 7, 15 -> rate_valid high exactly at cycle 17 for one cycle; rate=3, segments=0x4F. Next window with no spikes -> rate=0 at cycle 33.
- Held level, WINDOW_CYCLES=16: spike high for 5 consecutive cycles, plus a spike in the LATCH cycle -> first window rate=1, second window rate=1 (the LATCH-cycle edge is counted into window 2).
- Saturation, WINDOW_CYCLES=40: 18 one-cycle spikes spaced 2 cycles apart -> rate=15, overflow=1, segments=0x71. Next window with 4 spikes -> rate=4, overflow=0, segments=0x66.
- Abort, WINDOW_CYCLES=16: latch rate=2, then 5 edges and drop enable at window cycle 10 -> no rate_valid, rate stays 2. Re-enable -> first window counts from 0, with full WINDOW_CYCLES+1 latency.
- Reset mid-window: rst at window cycle 8 with 4 edges counted -> all outputs at reset values. After re-enable, spikes before the reset do not appear in the next rate. With SPIKE_RATE_OVF_FLASH_EN and overflow=1, segments=0x00 for window cycles 8..15.
